// File: rtl/mux_pkg.sv
// Shared helpers for the pipelined mux tree: depth calculation and parameter legality.
package mux_pkg;

  localparam string NInErrMsg = "mux_tree_pipe: N_IN must be a power of two and >= 2";

  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = unsigned'(i + 1);
    end
    return r;
  endfunction

  function automatic bit n_in_ok(input int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/mux2_stage.sv
// One W-bit registered 2:1 mux cell with its own valid bit; loads only on enable with valid input.
module mux2_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic         sel,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  output logic [W-1:0] data,
  output logic         valid
);

  logic [W-1:0] data_q;
  logic         valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      valid_q <= load;
      // Hold data across bubbles so the register does not toggle needlessly.
      if (load) data_q <= sel ? hi : lo;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// N_IN:1 mux built as a tree of registered 2:1 stages, one pipeline stage per tree level,
// with a valid/ready handshake whose ready chain is combinational back through the stages.
module mux_tree_pipe
  import mux_pkg::*;
#(
  parameter int unsigned N_IN = 8,
  parameter int unsigned W    = 8,
  localparam int unsigned LVL = clog2_f(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN*W-1:0] in_data,
  input  logic [LVL-1:0]  in_sel,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [W-1:0]    out_data,
  output logic [LVL-1:0]  out_sel,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [LVL-1:0] stage_valid;
  logic [LVL-1:0] stage_en;

  if (!n_in_ok(N_IN)) begin : g_param_err
    $error("%s", NInErrMsg);
  end

  // A stage may advance when it is empty or its successor advances; this squeezes out bubbles.
  always_comb begin
    logic r;
    r        = out_ready;
    stage_en = '0;
    for (int k = LVL - 1; k >= 0; k--) begin
      r           = !stage_valid[k] | r;
      stage_en[k] = r;
    end
  end

  assign in_ready = stage_en[0];

  for (genvar k = 0; k < LVL; k++) begin : g_lvl
    localparam int unsigned NOut = N_IN >> (k + 1);

    logic [2*NOut*W-1:0] din;
    logic [LVL-1:0]      din_sel;
    logic                din_valid;
    logic [NOut*W-1:0]   dout;
    logic [NOut-1:0]     vld;
    logic [LVL-1:0]      sel_q;

    if (k == 0) begin : g_src
      assign din       = in_data;
      assign din_sel   = in_sel;
      assign din_valid = in_valid;
    end else begin : g_src
      assign din       = g_lvl[k-1].dout;
      assign din_sel   = g_lvl[k-1].sel_q;
      assign din_valid = stage_valid[k-1];
    end

    for (genvar j = 0; j < NOut; j++) begin : g_pair
      mux2_stage #(
        .W(W)
      ) u_mux (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (stage_en[k]),
        .load (din_valid),
        .sel  (din_sel[k]),
        .lo   (din[(2*j)*W +: W]),
        .hi   (din[(2*j+1)*W +: W]),
        .data (dout[j*W +: W]),
        .valid(vld[j])
      );
    end

    // All cells of a level share one handshake, so their valid bits are identical.
    assign stage_valid[k] = &vld;

    // The full select travels with the word so the output can report it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sel_q <= '0;
      end else if (stage_en[k] && din_valid) begin
        sel_q <= din_sel;
      end
    end
  end

  assign out_data  = g_lvl[LVL-1].dout;
  assign out_sel   = g_lvl[LVL-1].sel_q;
  assign out_valid = stage_valid[LVL-1];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe: 8:1 x 8 directed vectors plus 2:1 x 1 and 16:1 x 32 streams.
module tb_mux_tree_pipe;

  typedef struct packed {
    logic [3:0]  s;
    logic [31:0] d;
  } item_t;

  logic clk;
  logic rst_n;

  logic [63:0]  in_data8;
  logic [2:0]   in_sel8;
  logic         in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]   out_data8;
  logic [2:0]   out_sel8;

  logic [1:0]   in_data2;
  logic [0:0]   in_sel2;
  logic         in_valid2, in_ready2, out_valid2, out_ready2;
  logic [0:0]   out_data2;
  logic [0:0]   out_sel2;

  logic [511:0] in_data16;
  logic [3:0]   in_sel16;
  logic         in_valid16, in_ready16, out_valid16, out_ready16;
  logic [31:0]  out_data16;
  logic [3:0]   out_sel16;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out8  = 0;
  int n_acc2  = 0, n_out2 = 0, n_acc16 = 0, n_out16 = 0;
  item_t q8[$], q2[$], q16[$];

  mux_tree_pipe #(.N_IN(8), .W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data8), .in_sel(in_sel8), .in_valid(in_valid8),
    .in_ready(in_ready8), .out_data(out_data8), .out_sel(out_sel8), .out_valid(out_valid8),
    .out_ready(out_ready8)
  );

  mux_tree_pipe #(.N_IN(2), .W(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_sel(in_sel2), .in_valid(in_valid2),
    .in_ready(in_ready2), .out_data(out_data2), .out_sel(out_sel2), .out_valid(out_valid2),
    .out_ready(out_ready2)
  );

  mux_tree_pipe #(.N_IN(16), .W(32)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data16), .in_sel(in_sel16), .in_valid(in_valid16),
    .in_ready(in_ready16), .out_data(out_data16), .out_sel(out_sel16), .out_valid(out_valid16),
    .out_ready(out_ready16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboards: compare outputs in order at each output transfer, then record new accepts.
  always @(negedge clk) begin : mon8
    item_t it;
    if (rst_n) begin
      if (out_valid8 && out_ready8) begin
        n_out8++;
        check("dut8_have_expected", 64'(q8.size() != 0), 64'd1);
        if (q8.size() != 0) begin
          it = q8.pop_front();
          check("dut8_data", 64'(out_data8), 64'(it.d[7:0]));
          check("dut8_sel", 64'(out_sel8), 64'(it.s[2:0]));
        end
      end
      if (in_valid8 && in_ready8)
        q8.push_back('{s: 4'(in_sel8), d: 32'(8'h10 + 8'(in_sel8))});
    end
  end

  always @(negedge clk) begin : mon2
    item_t it;
    if (rst_n) begin
      if (out_valid2 && out_ready2) begin
        n_out2++;
        check("dut2_have_expected", 64'(q2.size() != 0), 64'd1);
        if (q2.size() != 0) begin
          it = q2.pop_front();
          check("dut2_data", 64'(out_data2), 64'(it.d[0]));
          check("dut2_sel", 64'(out_sel2), 64'(it.s[0]));
        end
      end
      if (in_valid2 && in_ready2) begin
        n_acc2++;
        q2.push_back('{s: 4'(in_sel2), d: 32'(in_data2[in_sel2])});
      end
    end
  end

  always @(negedge clk) begin : mon16
    item_t it;
    logic         stalled;
    logic [31:0]  held;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled && out_valid16) check("dut16_hold", 64'(out_data16), 64'(held));
      stalled = out_valid16 && !out_ready16;
      held    = out_data16;
      if (out_valid16 && out_ready16) begin
        n_out16++;
        check("dut16_have_expected", 64'(q16.size() != 0), 64'd1);
        if (q16.size() != 0) begin
          it = q16.pop_front();
          check("dut16_data", 64'(out_data16), 64'(it.d));
          check("dut16_sel", 64'(out_sel16), 64'(it.s));
        end
      end
      if (in_valid16 && in_ready16) begin
        n_acc16++;
        q16.push_back('{s: in_sel16, d: in_data16[in_sel16*32 +: 32]});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, failed=%0d", n_fail);
    $fatal(1, "timeout");
  end

  task automatic idle8(input int n);
    @(posedge clk); #1;
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [2:0] seq3 [6];
    int idx;
    int n0;
    seq3 = '{3'd5, 3'd2, 3'd7, 3'd1, 3'd3, 3'd6};
    for (int i = 0; i < 8; i++) in_data8[i*8 +: 8] = 8'h10 + 8'(i);
    rst_n = 1'b0;
    in_valid8 = 1'b1; in_sel8 = 3'd3; out_ready8 = 1'b1;
    in_valid2 = 1'b0; in_sel2 = '0; in_data2 = '0; out_ready2 = 1'b1;
    in_valid16 = 1'b0; in_sel16 = '0; in_data16 = '0; out_ready16 = 1'b1;

    // Reset held for 3 cycles with in_valid asserted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid8), 64'd0);
      check("rst_out_data", 64'(out_data8), 64'd0);
      check("rst_out_sel", 64'(out_sel8), 64'd0);
    end
    check("rst_dut2_out_valid", 64'(out_valid2), 64'd0);
    check("rst_dut16_out_valid", 64'(out_valid16), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid8 = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready8), 64'd1);

    // Back-to-back selects 0..7, latency 3.
    for (int t = 0; t < 12; t++) begin
      @(posedge clk); #1;
      in_valid8 = (t < 8);
      in_sel8   = 3'(t);
      @(negedge clk);
      check("seq_in_ready", 64'(in_ready8), 64'd1);
      if (t < 3 || t >= 11) begin
        check("seq_out_valid_lo", 64'(out_valid8), 64'd0);
      end else begin
        check("seq_out_valid", 64'(out_valid8), 64'd1);
        check("seq_out_data", 64'(out_data8), 64'(16 + t - 3));
        check("seq_out_sel", 64'(out_sel8), 64'(t - 3));
      end
    end
    idle8(5);

    // Backpressure: out_ready low for cycles 2..6 while streaming 6 words.
    idx = 0;
    n0  = n_out8;
    for (int t = 0; t < 30; t++) begin
      @(posedge clk); #1;
      out_ready8 = !(t >= 2 && t < 7);
      in_valid8  = (idx < 6);
      if (idx < 6) in_sel8 = seq3[idx];
      @(negedge clk);
      if (t == 2) check("bp_in_ready_t2", 64'(in_ready8), 64'd1);
      if (t >= 3 && t < 7) begin
        check("bp_in_ready_low", 64'(in_ready8), 64'd0);
        check("bp_out_valid", 64'(out_valid8), 64'd1);
        check("bp_out_data_held", 64'(out_data8), 64'h15);
        check("bp_out_sel_held", 64'(out_sel8), 64'd5);
      end
      if (in_valid8 && in_ready8) idx++;
    end
    idle8(2);
    check("bp_words_sent", 64'(idx), 64'd6);
    check("bp_words_out", 64'(n_out8 - n0), 64'd6);

    // Bubbles: valid on even cycles, sel 7,0,7,0.
    for (int t = 0; t < 11; t++) begin
      @(posedge clk); #1;
      in_valid8 = (t < 8) && (t % 2 == 0);
      in_sel8   = (t % 4 == 0) ? 3'd7 : 3'd0;
      @(negedge clk);
      if (t >= 3) begin
        if (t <= 9 && ((t - 3) % 2 == 0)) begin
          check("bub_out_valid", 64'(out_valid8), 64'd1);
          check("bub_out_data", 64'(out_data8), ((t - 3) % 4 == 0) ? 64'h17 : 64'h10);
        end else begin
          check("bub_out_valid_lo", 64'(out_valid8), 64'd0);
        end
      end
    end
    idle8(4);

    // Reset with three words in flight.
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      in_valid8 = 1'b1;
      in_sel8   = 3'(t + 1);
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    n0 = n_out8;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid8), 64'd0);
    check("mid_rst_out_data", 64'(out_data8), 64'd0);
    q8.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      check("mid_rst_no_output", 64'(out_valid8), 64'd0);
    end
    check("mid_rst_out_count", 64'(n_out8 - n0), 64'd0);

    // Single-word latency on the 2:1 and 16:1 instances.
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
      in_valid2  = (t == 0);
      in_sel2    = 1'b1;
      in_data2   = 2'b10;
      in_valid16 = (t == 0);
      in_sel16   = 4'd9;
      for (int i = 0; i < 16; i++) in_data16[i*32 +: 32] = 32'hA000_0000 + 32'(i);
      @(negedge clk);
      check("lat_dut2", 64'(out_valid2), 64'(t == 1));
      check("lat_dut16", 64'(out_valid16), 64'(t == 4));
      if (t == 4) check("lat_dut16_data", 64'(out_data16), 64'hA000_0009);
    end

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      in_valid2   = 1'($urandom_range(0, 1));
      in_sel2     = 1'($urandom);
      in_data2    = 2'($urandom);
      out_ready2  = ($urandom_range(0, 3) != 0);
      in_valid16  = ($urandom_range(0, 3) != 0);
      in_sel16    = 4'($urandom);
      for (int i = 0; i < 16; i++) in_data16[i*32 +: 32] = $urandom;
      out_ready16 = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    in_valid2 = 1'b0; out_ready2 = 1'b1;
    in_valid16 = 1'b0; out_ready16 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rnd_dut2_drained", 64'(q2.size()), 64'd0);
    check("rnd_dut16_drained", 64'(q16.size()), 64'd0);
    check("rnd_dut2_count", 64'(n_out2), 64'(n_acc2));
    check("rnd_dut16_count", 64'(n_out16), 64'(n_acc16));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
